// File: rtl/store_buffer_if.sv
// Store-request and memory-write-port bundle for store_buffer.
// master: pipeline/memory side; slave: the buffer itself.
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     st_valid;
    logic                     st_ready;
    logic [31:0]              st_addr;
    logic [31:0]              st_data;
    logic [1:0]               st_width;
    logic                     st_exc;
    logic [31:0]              exc_addr;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_be;
    logic                     mem_ack;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output st_valid, st_addr, st_data, st_width, mem_ack,
        input  st_ready, st_exc, exc_addr, mem_req, mem_addr, mem_wdata,
               mem_be, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_width, mem_ack,
        output st_ready, st_exc, exc_addr, mem_req, mem_addr, mem_wdata,
               mem_be, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: alignment check, byte-lane formation and DEPTH-entry write FIFO.
// Optional STORE_MERGE_EN: legal stores to the tail entry's word merge into it.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [29:0]   r_waddr [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    logic [3:0]    r_be    [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_exc;
    logic [31:0]   r_exc_addr;

    logic          w_accept;
    logic          w_legal;
    logic          w_push;
    logic          w_pop;
    logic          w_merge;
    logic [3:0]    w_be;
    logic [31:0]   w_data;

    always_comb begin
        w_legal = 1'b0;
        w_be    = '0;
        w_data  = sb.st_data;
        case (sb.st_width)
            2'b00: begin
                w_legal = (sb.st_addr[1:0] == 2'b00);
                w_be    = 4'b1111;
            end
            2'b01: begin
                w_legal = !sb.st_addr[0];
                w_be    = sb.st_addr[1] ? 4'b1100 : 4'b0011;
                w_data  = {2{sb.st_data[15:0]}};
            end
            2'b10: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << sb.st_addr[1:0];
                w_data  = {4{sb.st_data[7:0]}};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Ready depends on count alone, so mem_ack never reaches st_ready combinationally.
    assign sb.st_ready = (r_count != FULL);
    assign w_accept    = sb.st_valid && sb.st_ready;
    assign w_pop       = (r_count != '0) && sb.mem_ack;

`ifdef STORE_MERGE_EN
    logic [AW-1:0] w_last;
    assign w_last  = r_tail - 1'b1;
    assign w_merge = w_accept && w_legal && (r_count >= (AW+1)'(2)) &&
                     (r_waddr[w_last] == sb.st_addr[31:2]);
`else
    assign w_merge = 1'b0;
`endif

    assign w_push = w_accept && w_legal && !w_merge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waddr    <= '{default: '0};
            r_data     <= '{default: '0};
            r_be       <= '{default: '0};
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_exc      <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_exc <= w_accept && !w_legal;
            if (w_accept && !w_legal) begin
                r_exc_addr <= sb.st_addr;
            end
            if (w_push) begin
                r_waddr[r_tail] <= sb.st_addr[31:2];
                r_data[r_tail]  <= w_data;
                r_be[r_tail]    <= w_be;
                r_tail          <= r_tail + 1'b1;
            end
`ifdef STORE_MERGE_EN
            // Tail is never the head here (count>=2), so a same-cycle pop cannot race it.
            if (w_merge) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_data[w_last][8*i +: 8] <= w_data[8*i +: 8];
                    end
                end
                r_be[w_last] <= r_be[w_last] | w_be;
            end
`endif
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign sb.mem_req   = (r_count != '0);
    assign sb.empty     = (r_count == '0);
    assign sb.count     = r_count;
    assign sb.mem_addr  = {r_waddr[r_head], 2'b00};
    assign sb.mem_wdata = r_data[r_head];
    assign sb.mem_be    = r_be[r_head];
    assign sb.st_exc    = r_exc;
    assign sb.exc_addr  = r_exc_addr;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table plus write/exception scoreboards.
// Build with +define+STORE_MERGE_EN to check the merging variant.
module tb_store_buffer;
    logic clk;
    logic reset;

    store_buffer_if #(.DEPTH(4)) bus ();

    store_buffer #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    typedef struct {
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exc;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } vec_t;

    int    n_pass  = 0;
    int    n_total = 0;
    ent_t  sb_q[$];
    logic [31:0] exc_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference lane formation from the store-width table.
    function automatic logic model(input logic [1:0] w, input logic [31:0] a,
                                   input logic [31:0] d, output ent_t e);
        e.addr = {a[31:2], 2'b00};
        e.data = d;
        e.be   = 4'b0000;
        case (w)
            2'b00: begin e.be = 4'hF; return a[1:0] == 2'b00; end
            2'b01: begin
                e.be   = a[1] ? 4'b1100 : 4'b0011;
                e.data = {d[15:0], d[15:0]};
                return !a[0];
            end
            2'b10: begin
                case (a[1:0])
                    2'd0: e.be = 4'b0001;
                    2'd1: e.be = 4'b0010;
                    2'd2: e.be = 4'b0100;
                    default: e.be = 4'b1000;
                endcase
                e.data = {4{d[7:0]}};
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        ent_t e;
        ent_t t;
        logic lg;
        int   sz;
        if (reset) begin
            sz = sb_q.size();
            if (bus.mem_req && bus.mem_ack) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write", {31'd0, bus.mem_req}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", bus.mem_addr, e.addr);
                    chk("wr_data", bus.mem_wdata, e.data);
                    chk("wr_be", {28'd0, bus.mem_be}, {28'd0, e.be});
                end
            end
            if (bus.st_exc) begin
                if (exc_q.size() == 0) chk("unexpected_exc", {31'd0, bus.st_exc}, 32'd0);
                else chk("exc_addr_sb", bus.exc_addr, exc_q.pop_front());
            end
            if (bus.st_valid && bus.st_ready) begin
                lg = model(bus.st_width, bus.st_addr, bus.st_data, e);
                if (!lg) begin
                    exc_q.push_back(bus.st_addr);
                end else begin
`ifdef STORE_MERGE_EN
                    if (sz >= 2 && sb_q[sb_q.size()-1].addr == e.addr) begin
                        t = sb_q[sb_q.size()-1];
                        for (int i = 0; i < 4; i++)
                            if (e.be[i]) t.data[8*i +: 8] = e.data[8*i +: 8];
                        t.be = t.be | e.be;
                        sb_q[sb_q.size()-1] = t;
                    end else begin
                        sb_q.push_back(e);
                    end
`else
                    sb_q.push_back(e);
`endif
                end
            end
        end
    end

    task automatic store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_width = w;
        bus.st_addr  = a;
        bus.st_data  = d;
        for (int k = 0; k < 20 && !bus.st_ready; k++) tick();
        if (!bus.st_ready) begin
            chk("store_ready_timeout", {31'd0, bus.st_ready}, 32'd1);
            bus.st_valid = 1'b0;
            return;
        end
        tick();
        bus.st_valid = 1'b0;
    endtask

    task automatic drain();
        bus.mem_ack = 1'b1;
        for (int k = 0; k < 12 && bus.count != 0; k++) tick();
        bus.mem_ack = 1'b0;
        chk("drain_count", 32'(bus.count), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t vt[9];

    initial begin : main
        vt[0] = '{2'b10, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
        vt[1] = '{2'b00, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111};
        vt[2] = '{2'b01, 32'h0000_5002, 32'h1234_CAFE, 1'b0, 32'h0000_5000, 32'hCAFE_CAFE, 4'b1100};
        vt[3] = '{2'b01, 32'h0000_5000, 32'h8765_0F0F, 1'b0, 32'h0000_5000, 32'h0F0F_0F0F, 4'b0011};
        vt[4] = '{2'b10, 32'h0000_6001, 32'hFFFF_FF55, 1'b0, 32'h0000_6000, 32'h5555_5555, 4'b0010};
        vt[5] = '{2'b01, 32'h0000_2001, 32'h0000_1111, 1'b1, 32'h0,         32'h0,         4'b0000};
        vt[6] = '{2'b00, 32'h0000_2002, 32'h0000_2222, 1'b1, 32'h0,         32'h0,         4'b0000};
        vt[7] = '{2'b11, 32'h0000_7000, 32'h0000_3333, 1'b1, 32'h0,         32'h0,         4'b0000};
        vt[8] = '{2'b00, 32'h0000_2001, 32'h0000_4444, 1'b1, 32'h0,         32'h0,         4'b0000};

        reset        = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_width = '0;
        bus.mem_ack  = 1'b0;
        repeat (3) tick();

        chk("rst_count",    32'(bus.count), 32'd0);
        chk("rst_empty",    {31'd0, bus.empty}, 32'd1);
        chk("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
        chk("rst_st_exc",   {31'd0, bus.st_exc}, 32'd0);
        chk("rst_exc_addr", bus.exc_addr, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_data", bus.mem_wdata, 32'd0);
        chk("rst_mem_be",   {28'd0, bus.mem_be}, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            store(vt[i].w, vt[i].a, vt[i].d);
            if (vt[i].exc) begin
                chk("vec_exc",       {31'd0, bus.st_exc}, 32'd1);
                chk("vec_exc_addr",  bus.exc_addr, vt[i].a);
                chk("vec_exc_count", 32'(bus.count), 32'd0);
                chk("vec_exc_noreq", {31'd0, bus.mem_req}, 32'd0);
                tick();
                chk("vec_exc_pulse", {31'd0, bus.st_exc}, 32'd0);
            end else begin
                chk("vec_req",   {31'd0, bus.mem_req}, 32'd1);
                chk("vec_addr",  bus.mem_addr, vt[i].maddr);
                chk("vec_wdata", bus.mem_wdata, vt[i].wdata);
                chk("vec_be",    {28'd0, bus.mem_be}, {28'd0, vt[i].be});
                chk("vec_count", 32'(bus.count), 32'd1);
                bus.mem_ack = 1'b1;
                tick();
                bus.mem_ack = 1'b0;
                chk("vec_popped", 32'(bus.count), 32'd0);
            end
        end

        // Back-to-back rejections give consecutive pulses.
        bus.st_valid = 1'b1; bus.st_width = 2'b11; bus.st_addr = 32'hA0;
        tick();
        bus.st_width = 2'b01; bus.st_addr = 32'hA5;
        chk("b2b_exc1",  {31'd0, bus.st_exc}, 32'd1);
        chk("b2b_addr1", bus.exc_addr, 32'hA0);
        tick();
        bus.st_valid = 1'b0;
        chk("b2b_exc2",  {31'd0, bus.st_exc}, 32'd1);
        chk("b2b_addr2", bus.exc_addr, 32'hA5);
        tick();
        chk("b2b_end",   {31'd0, bus.st_exc}, 32'd0);
        chk("exc_hold",  bus.exc_addr, 32'hA5);

        // Fill to full, then drain with a store waiting.
        for (int i = 0; i < 4; i++) store(2'b00, 32'h100 + 32'(4*i), 32'hC000_0000 + 32'(i));
        chk("full_ready", {31'd0, bus.st_ready}, 32'd0);
        chk("full_count", 32'(bus.count), 32'd4);
        bus.mem_ack = 1'b1;
        store(2'b00, 32'h110, 32'hC000_0004);
        chk("refill_count", 32'(bus.count), 32'd3);
        for (int k = 0; k < 10 && bus.count != 0; k++) begin
            chk("drain_req", {31'd0, bus.mem_req}, 32'd1);
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("drain_empty", {31'd0, bus.empty}, 32'd1);

        // Simultaneous accept and pop at count=2.
        store(2'b00, 32'h200, 32'h0000_0200);
        store(2'b00, 32'h204, 32'h0000_0204);
        bus.mem_ack = 1'b1;
        store(2'b00, 32'h208, 32'h0000_0208);
        bus.mem_ack = 1'b0;
        chk("simul_count", 32'(bus.count), 32'd2);
        drain();

        // Byte then half to the same word behind an older head entry.
        store(2'b00, 32'h3100, 32'h0000_3100);
        store(2'b10, 32'h3000, 32'h0000_0011);
        store(2'b01, 32'h3002, 32'h0000_2233);
`ifdef STORE_MERGE_EN
        chk("merge_count", 32'(bus.count), 32'd2);
`else
        chk("merge_count", 32'(bus.count), 32'd3);
`endif
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("merge_addr", bus.mem_addr, 32'h3000);
`ifdef STORE_MERGE_EN
        chk("merge_be",   {28'd0, bus.mem_be}, 32'b1101);
        chk("merge_data", bus.mem_wdata, 32'h2233_1111);
`else
        chk("merge_be",   {28'd0, bus.mem_be}, 32'b0001);
        chk("merge_data", bus.mem_wdata, 32'h1111_1111);
`endif
        drain();

        // Reset mid-drain with count=3 discards everything.
        store(2'b00, 32'h400, 32'h1);
        store(2'b00, 32'h404, 32'h2);
        store(2'b00, 32'h408, 32'h3);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        bus.mem_ack = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("mid_rst_be",    {28'd0, bus.mem_be}, 32'd0);
        sb_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        bus.mem_ack = 1'b0;
        chk("post_rst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("post_rst_count", 32'(bus.count), 32'd0);

        chk("sb_left",  32'(sb_q.size()), 32'd0);
        chk("exc_left", 32'(exc_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load data extractor: accepts store requests from the MEM stage, validates alignment, places the register value on the correct byte lanes with a 4-bit byte enable, and queues the result in a DEPTH-entry FIFO. The buffer drains to the data-memory/bridge write port over a req/ack handshake, so the pipeline never stalls on a slow write unless the buffer is full. Misaligned or reserved-width stores are rejected with a registered exception pulse and never reach memory.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; buffer is cleared while low.
- st_valid  in  1  store request present.
- st_ready  out  1  `!full`; a request is accepted on `st_valid && st_ready`.
- st_addr  in  32  byte address of the store.
- st_data  in  32  raw register value; the low bits are used for half and byte stores.
- st_width  in  2  store width: 00 word, 01 half, 10 byte, 11 reserved.
- st_exc  out  1  registered one-cycle pulse marking a rejected store.
- exc_addr  out  32  st_addr of the most recent rejected store; holds its value until the next rejection.
- mem_req  out  1  head entry valid.
- mem_addr  out  32  word address of the head entry; bits [1:0] are always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i covers lane [8i+7:8i].
- mem_ack  in  1  memory has taken the head entry.
- empty  out  1  count == 0.
- count  out  log2(DEPTH)+1  number of valid entries.

## Operation
Lane formation on accept:
- Word: be=1111, data=st_data. Legal only when addr[1:0]=00.
- Half: be=0011 when addr[1]=0, 1100 when addr[1]=1; data={2{st_data[15:0]}}. Legal only when addr[0]=0.
- Byte: be=0001<<addr[1:0]; data={4{st_data[7:0]}}. Always legal.
- Lanes with be=0 still carry the replicated value, so the output is deterministic.

Rejection:
- An accepted request that is misaligned, or has width 11, is consumed without being enqueued.
- The following cycle, st_exc=1 and exc_addr=st_addr.
- count is unchanged.

FIFO:
- Circular head and tail pointers wrap modulo DEPTH.
- mem_req=(count!=0). mem_addr, mem_wdata and mem_be always reflect the head entry.
- A pop occurs on the edge where mem_req && mem_ack. mem_ack while mem_req=0 is ignored.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- st_ready depends only on count, so there is no combinational path from mem_ack to st_ready.
- When full, a request is not accepted even if mem_ack is high in the same cycle.

Reset (reset low, at any time): count=0, both pointers 0, mem_req=0, mem_addr, mem_wdata and mem_be are 0, st_exc=0, exc_addr=0, empty=1. Pending entries are discarded, including an entry mid-handshake.

## Timing
- Enqueue-to-request latency is 1 cycle: a store accepted at edge N into an empty buffer gives mem_req=1 after edge N.
- mem_addr, mem_wdata and mem_be are held stable while mem_req=1 until the ack edge.
- With ack held high, back-to-back entries drain at one per cycle and mem_req stays high continuously.
- st_exc follows the rejected request by exactly 1 cycle and lasts 1 cycle. Back-to-back rejections give consecutive pulses.
- The FIFO has no fall-through path: a store can never reach memory in the same cycle it is accepted.

## Configuration
- Macro STORE_MERGE_EN, when defined:
  - An accepted legal store whose word address equals the tail entry's word address merges into that entry when count>=2 (the tail is not the entry being presented).
  - Merge: enabled lanes overwrite the data, and be is ORed.
  - count and pointers are unchanged.
  - Merges follow the st_ready rule (not accepted when full).
- Undefined: every legal store allocates a new entry.

## Test plan
- Reset low mid-drain with count=3 -> immediately mem_req=0, count=0, empty=1; after release, no stale write is issued.
- Byte store, addr 0x1003, data 0x000000AB -> next cycle mem_addr=0x1000, be=1000, wdata=0xABABABAB.
- Half store to 0x2001 -> st_exc pulses 1 cycle later, exc_addr=0x2001, count stays 0, no mem_req. A word store to 0x2002 behaves the same way.
- Fill 4 stores with ack=0 -> st_ready=0 and count=4. Raise ack with st_valid held -> one pop per cycle, a new accept on the first cycle with count<4, and entries leave in order.
- Simultaneous accept and ack at count=2 -> count stays 2 and order is preserved.
- STORE_MERGE_EN defined, ack=0: byte 0x11 to 0x3000, then half 0x2233 to 0x3002 while an older entry is at the head -> a single tail entry with be=1101, wdata lanes[31:16]=0x2233, lanes[7:0]=0x11. Without the macro -> two entries.
